atm_account_responder: RTL and testbench
========================================

Name: atm_account_responder

Overview:
Bank-side responder for the ATM controller's transaction requests. It accepts one request at a time over a valid/ready handshake and validates the PIN, enforcing a retry limit and a sticky lockout. It tracks the login session and executes balance, withdraw, deposit and transfer operations against a single account balance register. Each request returns exactly one status/balance response over a second valid/ready handshake.

Parameters:
INIT_BALANCE, 32'h000186A0, balance loaded on reset
ACCT_NO, 16'hD903, the card's own account number
PEER_ACCT, 16'hD904, only legal transfer destination
PIN_VALUE, 14'd8030, correct PIN
MAX_TRIES, 3, consecutive wrong PINs that cause lockout (range 1-3)
DAILY_LIMIT, 32'd20000, per-session debit cap (used only with the optional feature)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_op  in  3  operation: 000 logout, 001 balance, 010 withdraw, 011 deposit, 100 transfer, 101 login; 110 and 111 are illegal
req_pin  in  14  PIN (login only)
req_acct  in  16  ACCT_NO for login; destination account for transfer
req_amount  in  32  unsigned amount
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_status  out  4  0 OK, 1 BAD_PIN, 2 LOCKED, 3 NO_SESSION, 4 INSUFFICIENT, 5 BAD_ACCT, 6 OVERFLOW, 7 BAD_OP, 8 LIMIT
rsp_balance  out  32  balance after the operation; 0 for status NO_SESSION or LOCKED
locked  out  1  sticky lockout flag

Behaviour:
- Reset: FSM goes to IDLE, req_ready=1, rsp_valid=0, rsp_status=0, rsp_balance=0, locked=0, session=0, tries=0, balance=INIT_BALANCE. A reset mid-transaction aborts the request with no response and no balance change.
- FSM: IDLE -> CHECK -> EXEC -> RESP -> IDLE.
  - IDLE: req_ready=1. On req_valid&&req_ready, capture op/pin/acct/amount and go to CHECK. req_ready=0 in every other state.
  - CHECK (1 cycle): compute the status from the captured fields and current state, in this priority order:
    1. locked -> LOCKED
    2. illegal op -> BAD_OP
    3. op not login or logout with session=0 -> NO_SESSION
    4. op-specific checks
  - EXEC (1 cycle): update balance, session, tries and locked only when the status is OK, except for the tries/locked update described under login.
  - RESP: rsp_valid=1 and outputs held stable until rsp_ready; the handshake edge returns to IDLE.
- Latency: rsp_valid rises 2 clocks after the accept edge. Minimum request-to-request spacing is 4 clocks with rsp_ready tied high.
- login:
  - req_acct!=ACCT_NO -> BAD_ACCT; tries is unchanged.
  - Wrong PIN -> BAD_PIN and tries+1. When tries reaches MAX_TRIES: locked=1, session=0, status LOCKED for that response.
  - Correct PIN -> OK, session=1, tries=0.
  - Login while already in a session re-authenticates using the same rules.
- logout: always OK (unless locked); session=0; balance unchanged.
- balance: OK; returns the balance.
- withdraw:
  - amount>balance -> INSUFFICIENT, balance unchanged.
  - Otherwise balance-=amount. amount==balance gives 0 and OK. amount==0 gives OK with no change.
- deposit: the 33-bit sum is checked; a carry out -> OVERFLOW, balance unchanged. Otherwise balance+=amount.
- transfer:
  - req_acct!=PEER_ACCT -> BAD_ACCT. This check takes priority over INSUFFICIENT.
  - Otherwise the same rule as withdraw (the peer balance is not modelled).
- locked persists until reset. All requests are still handshaked and answered with LOCKED.
- req_valid asserted during a busy state is ignored until IDLE. Request fields are sampled only at the accept edge.

Optional Feature:
ATM_DAILY_LIMIT_EN:
- Defined: a 32-bit debit accumulator clears on reset, on logout, and on successful login. Withdraw and transfer check accumulator+amount>DAILY_LIMIT (33-bit compare) -> status LIMIT, with no change to balance or accumulator. LIMIT has priority after BAD_ACCT and before INSUFFICIENT. On success the accumulator += amount.
- Undefined: no accumulator exists and status 8 is never produced.

Test Plan:
1. Reset; login with acct D903, PIN 8030 -> OK, balance 100000; balance op -> OK, 100000, with rsp_valid 2 clocks after accept.
2. Withdraw 100001 -> INSUFFICIENT, 100000; withdraw 100000 -> OK, 0; deposit 5 -> OK, 5; deposit FFFFFFFF -> OVERFLOW, 5.
3. Logged out: withdraw 1 -> NO_SESSION, 0. Then 3 logins with PIN 1234 -> BAD_PIN, BAD_PIN, LOCKED with locked=1; a correct login afterwards -> LOCKED.
4. Transfer 10 to D903 -> BAD_ACCT; transfer 10 to D904 -> OK, 99990; op 111 -> BAD_OP, balance unchanged.
5. Hold rsp_ready low for 5 clocks: rsp_valid/status/balance remain stable and req_ready stays 0; assert reset during EXEC of a deposit -> no response, balance 100000.
6. With ATM_DAILY_LIMIT_EN defined: withdraw 15000 -> OK; withdraw 6000 -> LIMIT, 85000; logout, login, withdraw 6000 -> OK, 79000.

Source files
------------

// File: rtl/atm_account_responder.sv
// atm_account_responder
// Bank-side responder for ATM transaction requests. Each request is accepted
// over a valid/ready handshake, then checked (PIN, retry limit, lockout,
// session, funds) and executed against a single account balance. Exactly one
// status/balance response is returned per request.
//
// Optional feature: define ATM_DAILY_LIMIT_EN to add a per-session debit
// accumulator that caps withdraw/transfer totals at DAILY_LIMIT (status LIMIT).
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   req_valid/req_ready  request handshake
//   req_op               0 logout, 1 balance, 2 withdraw, 3 deposit,
//                        4 transfer, 5 login; 6/7 illegal
//   req_pin              PIN (login only)
//   req_acct             own account (login) or destination (transfer)
//   req_amount           unsigned amount
//   rsp_valid/rsp_ready  response handshake
//   rsp_status           0 OK,1 BAD_PIN,2 LOCKED,3 NO_SESSION,4 INSUFFICIENT,
//                        5 BAD_ACCT,6 OVERFLOW,7 BAD_OP,8 LIMIT
//   rsp_balance          balance after the op; 0 for LOCKED / NO_SESSION
//   locked               sticky lockout flag (cleared only by reset)
module atm_account_responder #(
`ifdef ATM_DAILY_LIMIT_EN
  parameter logic [31:0] DAILY_LIMIT  = 32'd20000,
`endif
  parameter logic [31:0] INIT_BALANCE = 32'h000186A0,
  parameter logic [15:0] ACCT_NO      = 16'hD903,
  parameter logic [15:0] PEER_ACCT    = 16'hD904,
  parameter logic [13:0] PIN_VALUE    = 14'd8030,
  parameter int          MAX_TRIES    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [13:0] req_pin,
  input  logic [15:0] req_acct,
  input  logic [31:0] req_amount,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [3:0]  rsp_status,
  output logic [31:0] rsp_balance,
  output logic        locked
);

  localparam logic [2:0] OP_LOGOUT   = 3'd0;
  localparam logic [2:0] OP_BALANCE  = 3'd1;
  localparam logic [2:0] OP_WITHDRAW = 3'd2;
  localparam logic [2:0] OP_DEPOSIT  = 3'd3;
  localparam logic [2:0] OP_TRANSFER = 3'd4;
  localparam logic [2:0] OP_LOGIN    = 3'd5;

  localparam logic [3:0] ST_OK       = 4'd0;
  localparam logic [3:0] ST_BAD_PIN  = 4'd1;
  localparam logic [3:0] ST_LOCKED   = 4'd2;
  localparam logic [3:0] ST_NO_SESS  = 4'd3;
  localparam logic [3:0] ST_INSUFF   = 4'd4;
  localparam logic [3:0] ST_BAD_ACCT = 4'd5;
  localparam logic [3:0] ST_OVERFLOW = 4'd6;
  localparam logic [3:0] ST_BAD_OP   = 4'd7;
`ifdef ATM_DAILY_LIMIT_EN
  localparam logic [3:0] ST_LIMIT    = 4'd8;
`endif

  localparam logic [1:0] MAX_T = MAX_TRIES[1:0];

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_EXEC, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [2:0]  op_q;
  logic [13:0] pin_q;
  logic [15:0] acct_q;
  logic [31:0] amount_q;
  logic [31:0] balance;
  logic        session;
  logic [1:0]  tries;
  logic [1:0]  tries_inc;
  logic [3:0]  status_q, status_c;
  logic [31:0] result_q, result_c;
  logic [32:0] sum33;
`ifdef ATM_DAILY_LIMIT_EN
  logic [31:0] acc;
  logic [32:0] acc_sum;
`endif

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign tries_inc = tries + 2'd1;
  assign sum33     = {1'b0, balance} + {1'b0, amount_q};
`ifdef ATM_DAILY_LIMIT_EN
  assign acc_sum   = {1'b0, acc} + {1'b0, amount_q};
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_valid) state_nxt = S_CHECK;
      S_CHECK: state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Status priority: lockout, illegal op, missing session, then op-specific.
  // result_c is the balance the op would leave behind; for any failure it is
  // the current balance.
  always_comb begin
    status_c = ST_OK;
    result_c = balance;
    if (locked) begin
      status_c = ST_LOCKED;
    end else if (op_q > OP_LOGIN) begin
      status_c = ST_BAD_OP;
    end else if (op_q != OP_LOGIN && op_q != OP_LOGOUT && !session) begin
      status_c = ST_NO_SESS;
    end else begin
      case (op_q)
        OP_LOGIN: begin
          if (acct_q != ACCT_NO)       status_c = ST_BAD_ACCT;
          else if (pin_q != PIN_VALUE) status_c = (tries_inc == MAX_T) ? ST_LOCKED : ST_BAD_PIN;
        end
        OP_WITHDRAW, OP_TRANSFER: begin
          if (op_q == OP_TRANSFER && acct_q != PEER_ACCT) status_c = ST_BAD_ACCT;
`ifdef ATM_DAILY_LIMIT_EN
          else if (acc_sum > {1'b0, DAILY_LIMIT})         status_c = ST_LIMIT;
`endif
          else if (amount_q > balance)                    status_c = ST_INSUFF;
          else                                            result_c = balance - amount_q;
        end
        OP_DEPOSIT: begin
          if (sum33[32]) status_c = ST_OVERFLOW;
          else           result_c = sum33[31:0];
        end
        default: ;  // logout and balance always succeed here
      endcase
    end
  end

  // Captured request fields and check results are pure data, not reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req_valid) begin
      op_q     <= req_op;
      pin_q    <= req_pin;
      acct_q   <= req_acct;
      amount_q <= req_amount;
    end
    if (state == S_CHECK) begin
      status_q <= status_c;
      result_q <= result_c;
    end
  end

  // Execute stage: commit account state and load the response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      balance     <= INIT_BALANCE;
      session     <= 1'b0;
      tries       <= 2'd0;
      locked      <= 1'b0;
      rsp_status  <= 4'd0;
      rsp_balance <= 32'd0;
`ifdef ATM_DAILY_LIMIT_EN
      acc         <= 32'd0;
`endif
    end else if (state == S_EXEC) begin
      rsp_status  <= status_q;
      rsp_balance <= (status_q == ST_LOCKED || status_q == ST_NO_SESS) ? 32'd0 : result_q;
      if (status_q == ST_OK) begin
        case (op_q)
          OP_LOGIN: begin
            session <= 1'b1;
            tries   <= 2'd0;
`ifdef ATM_DAILY_LIMIT_EN
            acc     <= 32'd0;
`endif
          end
          OP_LOGOUT: begin
            session <= 1'b0;
`ifdef ATM_DAILY_LIMIT_EN
            acc     <= 32'd0;
`endif
          end
          OP_WITHDRAW, OP_TRANSFER: begin
            balance <= result_q;
`ifdef ATM_DAILY_LIMIT_EN
            acc     <= acc_sum[31:0];
`endif
          end
          OP_DEPOSIT: balance <= result_q;
          default: ;
        endcase
      end else if (status_q == ST_BAD_PIN) begin
        tries <= tries_inc;
      end else if (status_q == ST_LOCKED && !locked) begin
        // Only the final wrong PIN yields LOCKED while not yet locked.
        tries   <= tries_inc;
        locked  <= 1'b1;
        session <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_atm_account_responder.sv
// Directed self-checking bench for atm_account_responder.
module tb_atm_account_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [13:0] req_pin;
  logic [15:0] req_acct;
  logic [31:0] req_amount;
  logic        rsp_valid, rsp_ready;
  logic [3:0]  rsp_status;
  logic [31:0] rsp_balance;
  logic        locked;

  int tests = 0;
  int fails = 0;
  int lat;
  logic [3:0]  held_st;
  logic [31:0] held_bal;

  atm_account_responder dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_pin(req_pin), .req_acct(req_acct), .req_amount(req_amount),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_balance(rsp_balance), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for its response; leaves the
  // response consumed and the DUT back in IDLE.
  task automatic req(input logic [2:0] op, input logic [13:0] pin, input logic [15:0] acct,
                     input logic [31:0] amt, input logic [3:0] es, input logic [31:0] eb,
                     input string tag);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_pin = pin; req_acct = acct; req_amount = amt;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 3'd0; req_pin = '0; req_acct = '0; req_amount = '0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, " status"}, {28'd0, rsp_status}, {28'd0, es});
    chk({tag, " balance"}, rsp_balance, eb);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_op = '0; req_pin = '0; req_acct = '0; req_amount = '0;
    do_reset();
    chk("reset req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset rsp_status", {28'd0, rsp_status}, 32'd0);
    chk("reset rsp_balance", rsp_balance, 32'd0);
    chk("reset locked", {31'd0, locked}, 32'd0);

    // 1. login and balance with latency
    req(3'd5, 14'd8030, 16'hD903, 32'd0, 4'd0, 32'd100000, "login ok");
    req(3'd1, 14'd0, 16'd0, 32'd0, 4'd0, 32'd100000, "balance");
    chk("latency", lat, 32'd2);

    // 2. withdraw / deposit boundaries
    req(3'd2, 14'd0, 16'd0, 32'd100001, 4'd4, 32'd100000, "wd insufficient");
    req(3'd2, 14'd0, 16'd0, 32'd100000, 4'd0, 32'd0, "wd all");
    req(3'd3, 14'd0, 16'd0, 32'd5, 4'd0, 32'd5, "dep 5");
    req(3'd3, 14'd0, 16'd0, 32'hFFFFFFFF, 4'd6, 32'd5, "dep overflow");
    req(3'd2, 14'd0, 16'd0, 32'd0, 4'd0, 32'd5, "wd zero");

    // 3. no session, retries (BAD_ACCT does not count), lockout
    req(3'd0, 14'd0, 16'd0, 32'd0, 4'd0, 32'd5, "logout");
    req(3'd2, 14'd0, 16'd0, 32'd1, 4'd3, 32'd0, "wd no session");
    req(3'd5, 14'd1234, 16'hD903, 32'd0, 4'd1, 32'd5, "bad pin 1");
    req(3'd5, 14'd8030, 16'h1111, 32'd0, 4'd5, 32'd5, "login bad acct");
    req(3'd5, 14'd1234, 16'hD903, 32'd0, 4'd1, 32'd5, "bad pin 2");
    chk("not yet locked", {31'd0, locked}, 32'd0);
    req(3'd5, 14'd1234, 16'hD903, 32'd0, 4'd2, 32'd0, "bad pin 3");
    chk("locked flag", {31'd0, locked}, 32'd1);
    req(3'd5, 14'd8030, 16'hD903, 32'd0, 4'd2, 32'd0, "login while locked");
    req(3'd7, 14'd0, 16'd0, 32'd0, 4'd2, 32'd0, "bad op while locked");

    // 4. transfer and illegal ops
    do_reset();
    chk("locked cleared", {31'd0, locked}, 32'd0);
    req(3'd5, 14'd8030, 16'hD903, 32'd0, 4'd0, 32'd100000, "relogin");
    req(3'd4, 14'd0, 16'hD903, 32'd10, 4'd5, 32'd100000, "xfer own acct");
    req(3'd4, 14'd0, 16'hD903, 32'd200000, 4'd5, 32'd100000, "xfer acct before funds");
    req(3'd4, 14'd0, 16'hD904, 32'd10, 4'd0, 32'd99990, "xfer ok");
    req(3'd4, 14'd0, 16'hD904, 32'd99991, 4'd4, 32'd99990, "xfer insufficient");
    req(3'd7, 14'd0, 16'd0, 32'd0, 4'd7, 32'd99990, "op 7");
    req(3'd6, 14'd0, 16'd0, 32'd0, 4'd7, 32'd99990, "op 6");

    // 5a. response back-pressure
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_op = 3'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("bp rsp_valid", {31'd0, rsp_valid}, 32'd1);
    held_st = rsp_status; held_bal = rsp_balance;
    chk("bp status", {28'd0, held_st}, 32'd0);
    chk("bp balance", held_bal, 32'd99990);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_op = 3'd3; req_amount = 32'd7;
      @(posedge clk); #1;
      chk("bp hold valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp hold status", {28'd0, rsp_status}, 32'd0);
      chk("bp hold balance", rsp_balance, 32'd99990);
      chk("bp hold req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0; req_amount = '0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp released", {31'd0, rsp_valid}, 32'd0);
    // Deposit attempted during back-pressure must have been ignored.
    req(3'd1, 14'd0, 16'd0, 32'd0, 4'd0, 32'd99990, "bp ignored req");

    // 5b. reset while a deposit is in EXEC
    req_valid = 1'b1; req_op = 3'd3; req_amount = 32'd10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #2;
    chk("abort rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort req_ready", {31'd0, req_ready}, 32'd1);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort no rsp", {31'd0, rsp_valid}, 32'd0);
    req(3'd1, 14'd0, 16'd0, 32'd0, 4'd3, 32'd0, "no session after reset");
    req(3'd5, 14'd8030, 16'hD903, 32'd0, 4'd0, 32'd100000, "login after abort");

    // 6. daily limit
    req(3'd2, 14'd0, 16'd0, 32'd15000, 4'd0, 32'd85000, "wd 15000");
`ifdef ATM_DAILY_LIMIT_EN
    req(3'd2, 14'd0, 16'd0, 32'd6000, 4'd8, 32'd85000, "wd limit");
    req(3'd4, 14'd0, 16'hD903, 32'd6000, 4'd5, 32'd85000, "xfer acct before limit");
    req(3'd2, 14'd0, 16'd0, 32'd5000, 4'd0, 32'd80000, "wd to limit");
    req(3'd0, 14'd0, 16'd0, 32'd0, 4'd0, 32'd80000, "logout lim");
    req(3'd5, 14'd8030, 16'hD903, 32'd0, 4'd0, 32'd80000, "login lim");
    req(3'd2, 14'd0, 16'd0, 32'd6000, 4'd0, 32'd74000, "wd after relogin");
`else
    req(3'd2, 14'd0, 16'd0, 32'd6000, 4'd0, 32'd79000, "wd no limit");
    req(3'd4, 14'd0, 16'hD904, 32'd50000, 4'd0, 32'd29000, "xfer no limit");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
